// File: rtl/ssd_scan_ctrl_pkg.sv
// ============================================================================
// Module   : ssd_scan_ctrl_pkg
// Purpose  : Shared definitions for the seven-segment scan controller:
//            slot state encoding, digit count and the all-anodes-off pattern.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd_scan_ctrl_pkg;

    // Per-slot phase: DEAD keeps every anode off to suppress ghosting while
    // the digit nibble and anode select change; ON lights the selected digit.
    typedef enum logic [0:0] {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_e;

    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

endpackage : ssd_scan_ctrl_pkg

`default_nettype wire

// File: rtl/ssd_slot_timer.sv
// ============================================================================
// Module   : ssd_slot_timer
// Purpose  : Slot timing for the display scan. Counts DIV cycles per digit
//            slot, steps the digit index 0..3 and sequences DEAD -> ON within
//            each slot. Exposes the next-cycle index/phase so the consumer can
//            register its outputs in step with the timer.
// Ports    : clk             system clock
//            rst_n           asynchronous active-low reset
//            idx_next_o      digit index valid after the coming edge
//            state_on_next_o phase after the coming edge is ON
//            frame_end_o     coming edge ends slot 3 (frame boundary)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_slot_timer
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int DIV  = 100000,
    parameter int DEAD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx_next_o,
    output logic       state_on_next_o,
    output logic       frame_end_o
);

    localparam int             CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  c_cnt_last  = CW'(DIV - 1);
    // DEAD=0 never consults this compare; clamp so the cast stays in range.
    localparam logic [CW-1:0]  c_dead_last = CW'((DEAD > 0) ? DEAD - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    scan_state_e   state_q, state_d;
    logic          frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= ST_DEAD;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        state_d   = state_q;
        frame_end = 1'b0;
        if (cnt_q == c_cnt_last) begin
            cnt_d     = '0;
            idx_d     = idx_q + 2'd1;
            state_d   = (DEAD == 0) ? ST_ON : ST_DEAD;
            frame_end = (idx_q == 2'd3);
        end else if (state_q == ST_DEAD && (DEAD == 0 || cnt_q == c_dead_last)) begin
            state_d = ST_ON;
        end
    end

    assign idx_next_o      = idx_d;
    assign state_on_next_o = (state_d == ST_ON);
    assign frame_end_o     = frame_end;

endmodule : ssd_slot_timer

`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
// ============================================================================
// Module   : ssd_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//            seven-segment display. Feeds one nibble per slot to the hex
//            decoder and drives active-low anodes with dead time, leading-zero
//            blanking and frame-synchronous (tear-free) value updates.
// Ports    : clk            system clock
//            rst_n          asynchronous active-low reset
//            value_i[15:0]  value to display, [15:12] = leftmost digit 3
//            load_i         strobe: capture value_i into the pending register
//            blank_en_i     suppress leading zeros
//            dp_mask_i[3:0] decimal point enable per digit
//            digit_o[3:0]   nibble for the decoder
//            an_o[3:0]      active-low anode enables, an_o[k] = digit k
//            dp_n_o         active-low decimal point
//            frame_tick_o   one-cycle pulse at each frame boundary
//            upd_pending_o  a loaded value awaits the next frame boundary
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int DIV  = 100000,
    parameter int DEAD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic        load_i,
    input  logic        blank_en_i,
    input  logic [3:0]  dp_mask_i,
    output logic [3:0]  digit_o,
    output logic [3:0]  an_o,
    output logic        dp_n_o,
    output logic        frame_tick_o,
    output logic        upd_pending_o
);

    logic [1:0]            idx_next;
    logic                  state_on_next;
    logic                  frame_end;

    logic [15:0]           shown_q, shown_d;
    logic [15:0]           pending_q, pending_d;
    logic                  upd_pending_q, upd_pending_d;
    logic [3:0]            an_q, an_d;
    logic [3:0]            digit_q, digit_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_tick_q;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  lit;

    ssd_slot_timer #(
        .DIV  (DIV),
        .DEAD (DEAD)
    ) u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .idx_next_o      (idx_next),
        .state_on_next_o (state_on_next),
        .frame_end_o     (frame_end)
    );

    // All outputs are computed from next-cycle timer values and the value that
    // will be shown next cycle, so they switch on the same edge as the index.
    always_comb begin
        shown_d       = shown_q;
        pending_d     = pending_q;
        upd_pending_d = upd_pending_q;

        // Boundary transfer first; a coincident load then re-arms pending
        // with the new value, so nothing is lost.
        if (frame_end && upd_pending_q) begin
            shown_d       = pending_q;
            upd_pending_d = 1'b0;
        end
        if (load_i) begin
            pending_d     = value_i;
            upd_pending_d = 1'b1;
        end

        // Digit k blanks when it and every digit to its left are zero.
        lz_blank = '0;
        if (blank_en_i) begin
            lz_blank[1] = (shown_d[15:4]  == 12'h000);
            lz_blank[2] = (shown_d[15:8]  == 8'h00);
            lz_blank[3] = (shown_d[15:12] == 4'h0);
        end

        digit_d = shown_d[{idx_next, 2'b00} +: 4];
        lit     = state_on_next && !lz_blank[idx_next];
        an_d    = lit ? ~(4'b0001 << idx_next) : AN_OFF;
        dp_n_d  = lit ? ~dp_mask_i[idx_next] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_q       <= 16'h0000;
            pending_q     <= 16'h0000;
            upd_pending_q <= 1'b0;
            an_q          <= AN_OFF;
            digit_q       <= 4'h0;
            dp_n_q        <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            shown_q       <= shown_d;
            pending_q     <= pending_d;
            upd_pending_q <= upd_pending_d;
            an_q          <= an_d;
            digit_q       <= digit_d;
            dp_n_q        <= dp_n_d;
            frame_tick_q  <= frame_end;
        end
    end

    assign digit_o       = digit_q;
    assign an_o          = an_q;
    assign dp_n_o        = dp_n_q;
    assign frame_tick_o  = frame_tick_q;
    assign upd_pending_o = upd_pending_q;

endmodule : ssd_scan_ctrl

`default_nettype wire

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It sits directly upstream of the hex-to-segment decoder (4-bit nibble in, 8-bit active-low segments out, bit 0 = dp). It holds a 16-bit display value, selects one nibble per time slot and drives it to the decoder, and drives the active-low anode enables, with dead-time ghost suppression, leading-zero blanking and tear-free frame updates.

Parameters:
DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
DEAD, 16, cycles at the start of each slot with all anodes off; legal range 0..DIV-1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  16  hex value to display; [15:12] leftmost digit 3, [3:0] rightmost digit 0
load  input  1  1-cycle strobe; captures value into the pending register
blank_en  input  1  1 = suppress leading zeros
dp_mask  input  4  1 = light the decimal point of digit k (bit k)
digit  output  4  nibble for the decoder input
an  output  4  active-low anode enables, an[k] = digit k
dp_n  output  1  active-low decimal point; top level forms seg = {D[7:1], dp_n}
frame_tick  output  1  1-cycle pulse at each frame boundary (slot index 3 -> 0)
upd_pending  output  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Reset (async, rst_n=0): cnt=0, idx=0, state=DEAD, an=4'b1111, digit=0, dp_n=1, frame_tick=0, shown=16'h0000, pending=16'h0000, upd_pending=0. All outputs are registered.
- Slot counter: cnt counts 0..DIV-1. At cnt==DIV-1: cnt<=0, idx<=(idx+1) mod 4, state<=DEAD. Each slot lasts exactly DIV cycles; a frame lasts 4*DIV cycles.
- FSM: DEAD, where an=1111 and dp_n=1. At cnt==DEAD-1 it moves to ON. With DEAD=0 the slot enters ON directly. In ON: an[idx]=0 unless idx is blanked, all other an bits are 1, and dp_n=~dp_mask[idx]. A blanked digit has dp_n=1.
- digit = shown[4*idx+3 : 4*idx]. It updates on the same edge as idx and is stable for the whole slot, dead time included.
- Frame boundary (idx 3 -> 0 edge): frame_tick=1 for that cycle. If upd_pending=1: shown<=pending and upd_pending<=0. On that same edge, digit reflects the new shown[3:0].
- load: pending<=value and upd_pending<=1. A load while already pending overwrites pending (last wins). A load on the boundary edge transfers the old pending to shown, captures the new value into pending, and leaves upd_pending=1.
- Leading-zero blanking (blank_en=1): digit k in 1..3 is blanked iff shown nibbles k..3 are all zero. Digit 0 is never blanked. blank_en and dp_mask are sampled live, not frame-latched.
- Reset mid-slot: an goes to 1111 immediately with no clock edge. On release, the sequence restarts from idx=0 in DEAD.
- Width rule: cnt width is $clog2(DIV). No other arithmetic.

Decomposition:
- Shared package holds: state encoding (ST_DEAD, ST_ON), NUM_DIGITS=4, AN_OFF=4'b1111.
- One natural sub-module: ssd_slot_timer (cnt, idx, state, slot_end/frame_end strobes).
- The top instantiates ssd_scan_ctrl feeding the existing decoder.

Test Plan:
All tests use DIV=8, DEAD=2.
1. Reset, no load -> an=1111 for 2 cycles, then an=1110 for 6 cycles with digit=0 and dp_n=1; frame_tick first pulses 32 cycles after reset release.
2. load 16'h1234 in cycle 3 -> upd_pending=1 until the first boundary; from the next frame, slots show (an,digit) = (1110,4), (1101,3), (1011,2), (0111,1), each with 2 dead cycles of an=1111.
3. blank_en=1, shown=16'h0050 -> an stays 1111 in slots 3 and 2; slot 1 gives an=1101, digit=5; slot 0 gives an=1110, digit=0. With shown=16'h0000, only slot 0 is lit.
4. shown=16'h1234; load 16'hABCD during slot 1, then load 16'h5555 during slot 2 -> slots 1 to 3 still show 3,2,1; at the boundary frame_tick=1 and digit=5; 16'hABCD is never displayed.
5. In ON of slot 2, drive rst_n=0 asynchronously between clock edges -> an=1111 before the next edge; after release, the sequence restarts at idx=0 in DEAD and shown=0.
6. dp_mask=4'b0100 -> dp_n=0 only during the 6 ON cycles of slot 2, and 1 during its dead cycles and all other slots.
